// File: rtl/pwu_req_arbiter.sv
// pwu_req_arbiter
// Shares one PWU translation pipeline between N_REQ requesters. VA requests are
// arbitrated round-robin. The requester ID of every accepted VA is pushed into an
// in-order tag FIFO. PAs come back from the PWU in issue order, so each PA is
// steered to the requester whose tag sits at the FIFO head.
//
// Ports
//   clk_i, resetn_i          clock (posedge) and async active-low reset
//   req_va_i/_vld_i/_rdy_o   per-requester VA request channel
//   req_pa_o/_fault_o        PA and fault, broadcast to all requesters
//   req_pa_vld_o/_rdy_i      per-requester PA response handshake
//   pwu_va_o/_vld_o/_rdy_i   VA channel towards the PWU
//   pwu_pa_i/_vld_i/_fault_i/_rdy_o   PA channel from the PWU
//   quiesce_i                stop issuing new VAs; in-flight ones still drain
//   idle_o                   tag FIFO empty and no VA presented
//   err_unexp_o              sticky: PA arrived while no tag was outstanding
module pwu_req_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic                   clk_i,
    input  logic                   resetn_i,
    input  logic [N_REQ-1:0][31:0] req_va_i,
    input  logic [N_REQ-1:0]       req_va_vld_i,
    output logic [N_REQ-1:0]       req_va_rdy_o,
    output logic [27:0]            req_pa_o,
    output logic                   req_pa_fault_o,
    output logic [N_REQ-1:0]       req_pa_vld_o,
    input  logic [N_REQ-1:0]       req_pa_rdy_i,
    output logic [31:0]            pwu_va_o,
    output logic                   pwu_va_vld_o,
    input  logic                   pwu_va_rdy_i,
    input  logic [27:0]            pwu_pa_i,
    input  logic                   pwu_pa_vld_i,
    input  logic                   pwu_pa_fault_i,
    output logic                   pwu_pa_rdy_o,
    input  logic                   quiesce_i,
    output logic                   idle_o,
    output logic                   err_unexp_o
);

    localparam int IDW = $clog2(N_REQ);
    localparam int PW  = $clog2(MAX_OUTST);
    localparam int CW  = PW + 1;

    typedef enum logic {ARB, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   lock_id_q, lock_id_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic [IDW-1:0]   fifo_q [MAX_OUTST];

    logic             issue_en;
    logic             found;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   sel_id;
    logic             va_vld;
    logic             push;
    logic             pop;
    logic             empty;
    logic [IDW-1:0]   head;

    // Request side: round-robin search starting at rr_ptr, HOLD overrides it.
    always_comb begin
        issue_en = !quiesce_i && (count_q < CW'(MAX_OUTST));
        found    = 1'b0;
        cand     = '0;
        gnt_id   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDW'((int'(rr_ptr_q) + i) % N_REQ);
            if (!found && req_va_vld_i[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end

        va_vld = 1'b0;
        sel_id = gnt_id;
        if (state_q == HOLD) begin
            // Slot already committed: present it even under quiesce or full.
            va_vld = 1'b1;
            sel_id = lock_id_q;
        end else if (issue_en && found) begin
            va_vld = 1'b1;
        end
        // All handshake outputs stay low while reset is held.
        va_vld = va_vld && resetn_i;

        pwu_va_vld_o = va_vld;
        pwu_va_o     = req_va_i[sel_id];
        req_va_rdy_o = '0;
        req_va_rdy_o[sel_id] = va_vld && pwu_va_rdy_i;
        push = va_vld && pwu_va_rdy_i;
    end

    // Response side: the FIFO head decides which requester sees the PA.
    always_comb begin
        empty          = (count_q == '0);
        head           = fifo_q[rd_ptr_q];
        req_pa_o       = pwu_pa_i;
        req_pa_fault_o = pwu_pa_fault_i;
        req_pa_vld_o   = '0;
        pwu_pa_rdy_o   = 1'b0;
        if (resetn_i) begin
            if (empty) begin
                // Nobody owns this PA: accept and drop it.
                pwu_pa_rdy_o = 1'b1;
            end else begin
                req_pa_vld_o[head] = pwu_pa_vld_i;
                pwu_pa_rdy_o       = req_pa_rdy_i[head];
            end
        end
        pop    = !empty && pwu_pa_vld_i && pwu_pa_rdy_o;
        idle_o = empty && !va_vld;
        err_unexp_o = err_q;
    end

    // Next-state computation for FSM, pointers and counter.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q || (empty && pwu_pa_vld_i);

        if (push) begin
            state_d  = ARB;
            rr_ptr_d = (sel_id == IDW'(N_REQ - 1)) ? '0 : sel_id + IDW'(1);
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else if (va_vld && state_q == ARB) begin
            state_d   = HOLD;
            lock_id_d = gnt_id;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
        end
    end

    // Tag storage carries data only; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel_id;
        end
    end

endmodule

// File: tb/tb_pwu_req_arbiter.sv
module tb_pwu_req_arbiter;

    logic              clk_i = 1'b0;
    logic              resetn_i;
    logic [3:0][31:0]  req_va_i;
    logic [3:0]        req_va_vld_i;
    logic [3:0]        req_va_rdy_o;
    logic [27:0]       req_pa_o;
    logic              req_pa_fault_o;
    logic [3:0]        req_pa_vld_o;
    logic [3:0]        req_pa_rdy_i;
    logic [31:0]       pwu_va_o;
    logic              pwu_va_vld_o;
    logic              pwu_va_rdy_i;
    logic [27:0]       pwu_pa_i;
    logic              pwu_pa_vld_i;
    logic              pwu_pa_fault_i;
    logic              pwu_pa_rdy_o;
    logic              quiesce_i;
    logic              idle_o;
    logic              err_unexp_o;

    int n_cmp = 0;
    int n_bad = 0;

    pwu_req_arbiter #(.N_REQ(4), .MAX_OUTST(8)) dut (
        .clk_i          (clk_i),
        .resetn_i       (resetn_i),
        .req_va_i       (req_va_i),
        .req_va_vld_i   (req_va_vld_i),
        .req_va_rdy_o   (req_va_rdy_o),
        .req_pa_o       (req_pa_o),
        .req_pa_fault_o (req_pa_fault_o),
        .req_pa_vld_o   (req_pa_vld_o),
        .req_pa_rdy_i   (req_pa_rdy_i),
        .pwu_va_o       (pwu_va_o),
        .pwu_va_vld_o   (pwu_va_vld_o),
        .pwu_va_rdy_i   (pwu_va_rdy_i),
        .pwu_pa_i       (pwu_pa_i),
        .pwu_pa_vld_i   (pwu_pa_vld_i),
        .pwu_pa_fault_i (pwu_pa_fault_i),
        .pwu_pa_rdy_o   (pwu_pa_rdy_o),
        .quiesce_i      (quiesce_i),
        .idle_o         (idle_o),
        .err_unexp_o    (err_unexp_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_va_i[0] = 32'h0000_1000;
        req_va_i[1] = 32'h0000_2000;
        req_va_i[2] = 32'h0000_3000;
        req_va_i[3] = 32'h0000_4000;
        req_va_vld_i   = 4'b0000;
        req_pa_rdy_i   = 4'b1111;
        pwu_va_rdy_i   = 1'b1;
        pwu_pa_i       = 28'h0;
        pwu_pa_vld_i   = 1'b0;
        pwu_pa_fault_i = 1'b0;
        quiesce_i      = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        resetn_i = 1'b0;
        tick();
        tick();
        resetn_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn_i = 1'b0;
        req_va_vld_i = 4'b1111;
        pwu_pa_vld_i = 1'b1;
        #3;
        n_cmp++;
        if (pwu_va_vld_o !== 1'b0) begin n_bad++; $display("FAIL rst_va_vld: got %b want 0", pwu_va_vld_o); end
        n_cmp++;
        if (req_va_rdy_o !== 4'b0000) begin n_bad++; $display("FAIL rst_va_rdy: got %b want 0000", req_va_rdy_o); end
        n_cmp++;
        if (pwu_pa_rdy_o !== 1'b0) begin n_bad++; $display("FAIL rst_pa_rdy: got %b want 0", pwu_pa_rdy_o); end
        n_cmp++;
        if (req_pa_vld_o !== 4'b0000) begin n_bad++; $display("FAIL rst_pa_vld: got %b want 0000", req_pa_vld_o); end
        tick();
        n_cmp++;
        if (err_unexp_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_unexp_o); end
        apply_reset();
        n_cmp++;
        if (idle_o !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %b want 1", idle_o); end
        n_cmp++;
        if (pwu_pa_rdy_o !== 1'b1) begin n_bad++; $display("FAIL rst_empty_pa_rdy: got %b want 1", pwu_pa_rdy_o); end
    endtask

    task automatic test_single();
        apply_reset();
        req_va_i[1] = 32'h0000_1234;
        req_va_vld_i = 4'b0010;
        #1;
        n_cmp++;
        if (pwu_va_vld_o !== 1'b1 || pwu_va_o !== 32'h0000_1234) begin
            n_bad++; $display("FAIL single_va: got vld=%b va=%h want 1 00001234", pwu_va_vld_o, pwu_va_o);
        end
        n_cmp++;
        if (req_va_rdy_o !== 4'b0010) begin n_bad++; $display("FAIL single_va_rdy: got %b want 0010", req_va_rdy_o); end
        tick();
        req_va_vld_i = 4'b0000;
        repeat (4) tick();
        pwu_pa_i = 28'h0ABC_DEF;
        pwu_pa_vld_i = 1'b1;
        #1;
        n_cmp++;
        if (req_pa_vld_o !== 4'b0010) begin n_bad++; $display("FAIL single_pa_vld: got %b want 0010", req_pa_vld_o); end
        n_cmp++;
        if (req_pa_o !== 28'h0ABC_DEF) begin n_bad++; $display("FAIL single_pa: got %h want 0abcdef", req_pa_o); end
        n_cmp++;
        if (pwu_pa_rdy_o !== 1'b1) begin n_bad++; $display("FAIL single_pa_rdy: got %b want 1", pwu_pa_rdy_o); end
        tick();
        pwu_pa_vld_i = 1'b0;
        #1;
        n_cmp++;
        if (idle_o !== 1'b1) begin n_bad++; $display("FAIL single_idle: got %b want 1", idle_o); end
    endtask

    task automatic test_rr();
        logic [3:0]  exp_vld;
        logic [31:0] exp_va;
        apply_reset();
        req_va_vld_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_vld = 4'b0001 << (k % 4);
            exp_va  = 32'h0000_1000 * ((k % 4) + 1);
            n_cmp++;
            if (req_va_rdy_o !== exp_vld || pwu_va_o !== exp_va) begin
                n_bad++; $display("FAIL rr_grant%0d: got rdy=%b va=%h want %b %h", k, req_va_rdy_o, pwu_va_o, exp_vld, exp_va);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (pwu_va_vld_o !== 1'b0) begin n_bad++; $display("FAIL rr_full: got %b want 0", pwu_va_vld_o); end
        req_va_vld_i = 4'b0000;
        pwu_pa_vld_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pwu_pa_i = 28'h100 + 28'(k);
            #1;
            exp_vld = 4'b0001 << (k % 4);
            n_cmp++;
            if (req_pa_vld_o !== exp_vld || req_pa_o !== 28'h100 + 28'(k)) begin
                n_bad++; $display("FAIL rr_resp%0d: got vld=%b pa=%h want %b %h", k, req_pa_vld_o, req_pa_o, exp_vld, 28'h100 + 28'(k));
            end
            tick();
        end
        pwu_pa_vld_i = 1'b0;
        #1;
        n_cmp++;
        if (idle_o !== 1'b1) begin n_bad++; $display("FAIL rr_idle: got %b want 1", idle_o); end
    endtask

    task automatic test_lock();
        apply_reset();
        pwu_va_rdy_i = 1'b0;
        req_va_vld_i = 4'b0100;
        #1;
        n_cmp++;
        if (pwu_va_vld_o !== 1'b1 || pwu_va_o !== 32'h0000_3000 || req_va_rdy_o !== 4'b0000) begin
            n_bad++; $display("FAIL lock_first: got vld=%b va=%h rdy=%b want 1 00003000 0000", pwu_va_vld_o, pwu_va_o, req_va_rdy_o);
        end
        tick();
        req_va_vld_i = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (pwu_va_o !== 32'h0000_3000 || pwu_va_vld_o !== 1'b1) begin
                n_bad++; $display("FAIL lock_hold%0d: got vld=%b va=%h want 1 00003000", k, pwu_va_vld_o, pwu_va_o);
            end
            tick();
        end
        pwu_va_rdy_i = 1'b1;
        #1;
        n_cmp++;
        if (req_va_rdy_o !== 4'b0100) begin n_bad++; $display("FAIL lock_accept: got %b want 0100", req_va_rdy_o); end
        tick();
        req_va_vld_i = 4'b1001;
        #1;
        n_cmp++;
        if (req_va_rdy_o !== 4'b1000) begin n_bad++; $display("FAIL lock_next3: got %b want 1000", req_va_rdy_o); end
        tick();
        req_va_vld_i = 4'b0001;
        #1;
        n_cmp++;
        if (req_va_rdy_o !== 4'b0001) begin n_bad++; $display("FAIL lock_next0: got %b want 0001", req_va_rdy_o); end
        tick();
        req_va_vld_i = 4'b0000;
    endtask

    task automatic test_full();
        apply_reset();
        req_va_vld_i = 4'b0001;
        repeat (8) tick();
        #1;
        n_cmp++;
        if (pwu_va_vld_o !== 1'b0 || req_va_rdy_o !== 4'b0000) begin
            n_bad++; $display("FAIL full_block: got vld=%b rdy=%b want 0 0000", pwu_va_vld_o, req_va_rdy_o);
        end
        pwu_pa_vld_i = 1'b1;
        #1;
        n_cmp++;
        if (pwu_va_vld_o !== 1'b0) begin n_bad++; $display("FAIL full_pop_same_cycle: got %b want 0", pwu_va_vld_o); end
        tick();
        pwu_pa_vld_i = 1'b0;
        #1;
        n_cmp++;
        if (pwu_va_vld_o !== 1'b1 || req_va_rdy_o !== 4'b0001) begin
            n_bad++; $display("FAIL full_ninth: got vld=%b rdy=%b want 1 0001", pwu_va_vld_o, req_va_rdy_o);
        end
        tick();
        req_va_vld_i = 4'b0000;
        pwu_pa_vld_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if (req_pa_vld_o !== 4'b0001) begin n_bad++; $display("FAIL full_drain%0d: got %b want 0001", k, req_pa_vld_o); end
            tick();
        end
        pwu_pa_vld_i = 1'b0;
        #1;
        n_cmp++;
        if (idle_o !== 1'b1) begin n_bad++; $display("FAIL full_idle: got %b want 1", idle_o); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_va_vld_i = 4'b0010;
        tick();
        req_va_vld_i = 4'b0100;
        tick();
        req_va_vld_i = 4'b0000;
        pwu_pa_vld_i = 1'b1;
        pwu_pa_i     = 28'h0000_555;
        req_pa_rdy_i = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (pwu_pa_rdy_o !== 1'b0 || req_pa_vld_o !== 4'b0010) begin
                n_bad++; $display("FAIL bp_stall%0d: got rdy=%b vld=%b want 0 0010", k, pwu_pa_rdy_o, req_pa_vld_o);
            end
            tick();
        end
        req_pa_rdy_i = 4'b1111;
        #1;
        n_cmp++;
        if (pwu_pa_rdy_o !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", pwu_pa_rdy_o); end
        tick();
        #1;
        n_cmp++;
        if (req_pa_vld_o !== 4'b0100 || idle_o !== 1'b0) begin
            n_bad++; $display("FAIL bp_next_head: got vld=%b idle=%b want 0100 0", req_pa_vld_o, idle_o);
        end
        tick();
        pwu_pa_vld_i = 1'b0;
        #1;
        n_cmp++;
        if (idle_o !== 1'b1) begin n_bad++; $display("FAIL bp_idle: got %b want 1", idle_o); end
    endtask

    task automatic test_err_quiesce();
        apply_reset();
        pwu_pa_vld_i = 1'b1;
        #1;
        n_cmp++;
        if (pwu_pa_rdy_o !== 1'b1 || req_pa_vld_o !== 4'b0000) begin
            n_bad++; $display("FAIL err_discard: got rdy=%b vld=%b want 1 0000", pwu_pa_rdy_o, req_pa_vld_o);
        end
        tick();
        pwu_pa_vld_i = 1'b0;
        #1;
        n_cmp++;
        if (err_unexp_o !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err_unexp_o); end
        req_va_vld_i = 4'b1001;
        tick();
        req_va_vld_i = 4'b1000;
        tick();
        req_va_vld_i = 4'b1111;
        quiesce_i    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (pwu_va_vld_o !== 1'b0 || idle_o !== 1'b0) begin
                n_bad++; $display("FAIL q_block%0d: got vld=%b idle=%b want 0 0", k, pwu_va_vld_o, idle_o);
            end
            tick();
        end
        pwu_pa_vld_i = 1'b1;
        #1;
        n_cmp++;
        if (req_pa_vld_o !== 4'b0001) begin n_bad++; $display("FAIL q_pop0: got %b want 0001", req_pa_vld_o); end
        tick();
        #1;
        n_cmp++;
        if (req_pa_vld_o !== 4'b1000) begin n_bad++; $display("FAIL q_pop1: got %b want 1000", req_pa_vld_o); end
        tick();
        pwu_pa_vld_i = 1'b0;
        #1;
        n_cmp++;
        if (idle_o !== 1'b1 || err_unexp_o !== 1'b1) begin
            n_bad++; $display("FAIL q_idle: got idle=%b err=%b want 1 1", idle_o, err_unexp_o);
        end
        apply_reset();
        n_cmp++;
        if (err_unexp_o !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err_unexp_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_lock();
        test_full();
        test_backpressure();
        test_err_quiesce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
